// File: rtl/countdown_pkg.sv
// Shared state encoding, key-vector layout and decimal helpers for the
// countdown timer controller.
package countdown_pkg;

  typedef enum logic [2:0] {
    ST_SET   = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_WARN  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int KEY_INC   = 0;
  localparam int KEY_DEC   = 1;
  localparam int KEY_LEFT  = 2;
  localparam int KEY_RIGHT = 3;
  localparam int KEY_START = 4;
  localparam int KEY_CLEAR = 5;
  localparam int KEY_N     = 6;

  // 10^idx, truncated to width bits; constant-bounded loop so it elaborates cleanly.
  function automatic longint unsigned pow10(input int idx, input int width);
    longint unsigned r;
    r = 64'd1;
    for (int i = 0; i < 19; i++)
      if (i < idx) r = r * 64'd10;
    if (width < 64) r = r & ((64'd1 << width) - 64'd1);
    return r;
  endfunction

  function automatic longint unsigned max_value(input int digits);
    return pow10(digits, 64) - 64'd1;
  endfunction

endpackage

// File: rtl/countdown_timer_ctrl_key_edge.sv
// Rising-edge detector for a vector of debounced key levels.
module key_edge #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic [W-1:0] key_i,
  output logic [W-1:0] rise_o
);

  logic [W-1:0] hist_q;

  // History follows the keys even while the controller is in reset, so a key
  // held across reset release is not mistaken for a fresh press.
  always_ff @(posedge clk) begin
    hist_q <= key_i;
  end

  assign rise_o = key_i & ~hist_q;

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Countdown timer controller: digit-wise preset editing, run/pause/resume,
// warning region and done pulse, all outputs registered.
module countdown_timer_ctrl
  import countdown_pkg::*;
#(
  parameter int DIGITS     = 6,
  parameter int CNT_W      = 20,
  parameter int TICK_DIV   = 10,
  parameter int WARN_LEVEL = 300,
  parameter int SEL_INIT   = 2,
  parameter int POINT_MASK = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_inc,
  input  logic              key_dec,
  input  logic              key_left,
  input  logic              key_right,
  input  logic              key_start,
  input  logic              key_clear,
  output logic [CNT_W-1:0]  value,
  output logic [DIGITS-1:0] blink_mask,
  output logic [DIGITS-1:0] point_mask,
  output logic [2:0]        state,
  output logic              warn,
  output logic              done_pulse
);

  localparam int SEL_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] MAXV   = CNT_W'(max_value(DIGITS));
  localparam logic [CNT_W-1:0] WARN_V = CNT_W'(WARN_LEVEL);
  localparam logic [PRE_W-1:0] PRE_TOP = PRE_W'(TICK_DIV - 1);
  localparam logic [SEL_W-1:0] SEL_TOP = SEL_W'(DIGITS - 1);

  logic [KEY_N-1:0] keys, rise;
  logic inc_e, dec_e, left_e, right_e, start_e, clear_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   preset_q, preset_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [PRE_W-1:0]   presc_q, presc_d;
  logic [CNT_W-1:0]   value_q, value_d;
  logic [DIGITS-1:0]  blink_q, blink_d;
  logic               warn_q, warn_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   step;
  logic               tick;

  assign keys = {key_clear, key_start, key_right, key_left, key_dec, key_inc};

  key_edge #(.W(KEY_N)) u_key_edge (
    .clk    (clk),
    .key_i  (keys),
    .rise_o (rise)
  );

  assign inc_e   = rise[KEY_INC];
  assign dec_e   = rise[KEY_DEC];
  assign left_e  = rise[KEY_LEFT];
  assign right_e = rise[KEY_RIGHT];
  assign start_e = rise[KEY_START];
  assign clear_e = rise[KEY_CLEAR];

  assign tick = (presc_q == PRE_TOP);

  always_comb begin
    step = '0;
    for (int i = 0; i < DIGITS; i++)
      if (int'(sel_q) == i) step = CNT_W'(pow10(i, CNT_W));

    state_d  = state_q;
    preset_d = preset_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    presc_d  = presc_q;

    case (state_q)
      ST_SET: begin
        if (left_e && !right_e)
          sel_d = (sel_q == SEL_TOP) ? '0 : sel_q + SEL_W'(1);
        else if (right_e && !left_e)
          sel_d = (sel_q == '0) ? SEL_TOP : sel_q - SEL_W'(1);

        if (inc_e && !dec_e) begin
          if (preset_q <= MAXV - step) preset_d = preset_q + step;
        end else if (dec_e && !inc_e) begin
          if (preset_q >= step) preset_d = preset_q - step;
        end

        if (start_e && preset_q != '0) begin
          cnt_d   = preset_q;
          presc_d = '0;
          state_d = (preset_q <= WARN_V) ? ST_WARN : ST_RUN;
        end
      end
      ST_RUN, ST_WARN: begin
        // A pause on the wrap cycle wins; the prescaler stays where it was.
        if (start_e) begin
          state_d = ST_PAUSE;
        end else if (tick) begin
          presc_d = '0;
          cnt_d   = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1))
            state_d = ST_DONE;
          else if (cnt_q - CNT_W'(1) <= WARN_V)
            state_d = ST_WARN;
        end else begin
          presc_d = presc_q + PRE_W'(1);
        end
      end
      ST_PAUSE: begin
        if (clear_e)
          state_d = ST_SET;
        else if (start_e)
          state_d = (cnt_q <= WARN_V) ? ST_WARN : ST_RUN;
      end
      ST_DONE: begin
        if (start_e || clear_e) state_d = ST_SET;
      end
      default: state_d = ST_SET;
    endcase

    value_d = cnt_d;
    blink_d = '0;
    if (state_d == ST_SET) begin
      value_d = preset_d;
      blink_d = DIGITS'(1) << sel_d;
    end else if (state_d == ST_DONE) begin
      value_d = '0;
      blink_d = '1;
    end
    warn_d = (state_d == ST_WARN);
    done_d = (state_d == ST_DONE) && (state_q != ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_SET;
      preset_q <= '0;
      cnt_q    <= '0;
      sel_q    <= SEL_W'(SEL_INIT);
      presc_q  <= '0;
      value_q  <= '0;
      blink_q  <= DIGITS'(1) << SEL_INIT;
      warn_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      preset_q <= preset_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      presc_q  <= presc_d;
      value_q  <= value_d;
      blink_q  <= blink_d;
      warn_q   <= warn_d;
      done_q   <= done_d;
    end
  end

  assign value      = value_q;
  assign blink_mask = blink_q;
  assign point_mask = DIGITS'(POINT_MASK);
  assign state      = state_q;
  assign warn       = warn_q;
  assign done_pulse = done_q;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Scoreboard bench for countdown_timer_ctrl: directed key sequences plus
// random key traffic, checked against a behavioural timer model.
`timescale 1ns/1ps
module tb_countdown_timer_ctrl;

  localparam int DIGITS     = 6;
  localparam int CNT_W      = 20;
  localparam int TICK_DIV   = 2;
  localparam int WARN_LEVEL = 300;
  localparam int SEL_INIT   = 2;
  localparam int POINT_MASK = 6'b100100;

  localparam int M_SET = 0, M_RUN = 1, M_PAUSE = 2, M_WARN = 3, M_DONE = 4;
  localparam int K_INC = 0, K_DEC = 1, K_LEFT = 2, K_RIGHT = 3, K_START = 4, K_CLEAR = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_inc = 0, key_dec = 0, key_left = 0, key_right = 0, key_start = 0, key_clear = 0;
  logic [CNT_W-1:0]  value;
  logic [DIGITS-1:0] blink_mask, point_mask;
  logic [2:0]        state;
  logic              warn, done_pulse;

  countdown_timer_ctrl #(
    .DIGITS(DIGITS), .CNT_W(CNT_W), .TICK_DIV(TICK_DIV),
    .WARN_LEVEL(WARN_LEVEL), .SEL_INIT(SEL_INIT), .POINT_MASK(POINT_MASK)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .key_inc(key_inc), .key_dec(key_dec), .key_left(key_left),
    .key_right(key_right), .key_start(key_start), .key_clear(key_clear),
    .value(value), .blink_mask(blink_mask), .point_mask(point_mask),
    .state(state), .warn(warn), .done_pulse(done_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    int value;
    int blink;
    int st;
    int warn;
    int done_p;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: remaining clocks until next decrement instead of a prescaler.
  int m_st, m_preset, m_sel, m_cnt, m_tleft, m_done;
  bit [5:0] m_prev;

  function automatic int p10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  task automatic model_step(input bit [5:0] k, input bit rst);
    bit [5:0] e;
    int stp, old_preset, old_st;
    e = k & ~m_prev;
    m_prev = k;
    m_done = 0;
    if (rst) begin
      m_st = M_SET; m_preset = 0; m_sel = SEL_INIT; m_cnt = 0; m_tleft = TICK_DIV;
      return;
    end
    old_st = m_st;
    case (m_st)
      M_SET: begin
        stp = p10(m_sel);
        old_preset = m_preset;
        if (e[K_LEFT] && !e[K_RIGHT]) m_sel = (m_sel + 1) % DIGITS;
        else if (e[K_RIGHT] && !e[K_LEFT]) m_sel = (m_sel + DIGITS - 1) % DIGITS;
        if (e[K_INC] && !e[K_DEC] && old_preset + stp <= p10(DIGITS) - 1) m_preset = old_preset + stp;
        if (e[K_DEC] && !e[K_INC] && old_preset >= stp) m_preset = old_preset - stp;
        if (e[K_START] && old_preset != 0) begin
          m_cnt = old_preset;
          m_tleft = TICK_DIV;
          m_st = (old_preset <= WARN_LEVEL) ? M_WARN : M_RUN;
        end
      end
      M_RUN, M_WARN: begin
        if (e[K_START]) m_st = M_PAUSE;
        else begin
          m_tleft--;
          if (m_tleft == 0) begin
            m_tleft = TICK_DIV;
            m_cnt--;
            if (m_cnt == 0) m_st = M_DONE;
            else if (m_cnt <= WARN_LEVEL) m_st = M_WARN;
          end
        end
      end
      M_PAUSE: begin
        if (e[K_CLEAR]) m_st = M_SET;
        else if (e[K_START]) m_st = (m_cnt <= WARN_LEVEL) ? M_WARN : M_RUN;
      end
      default: if (e[K_START] || e[K_CLEAR]) m_st = M_SET;
    endcase
    m_done = (m_st == M_DONE && old_st != M_DONE) ? 1 : 0;
  endtask

  function automatic exp_t model_out();
    exp_t x;
    x.st = m_st;
    x.warn = (m_st == M_WARN) ? 1 : 0;
    x.done_p = m_done;
    x.value = m_cnt;
    x.blink = 0;
    if (m_st == M_SET) begin
      x.value = m_preset;
      x.blink = 1 << m_sel;
    end else if (m_st == M_DONE) begin
      x.value = 0;
      x.blink = (1 << DIGITS) - 1;
    end
    return x;
  endfunction

  // One clock of stimulus: drive, advance model, queue expected outputs.
  task automatic cyc(input bit [5:0] k, input bit rst);
    @(posedge clk);
    #2;
    rst_n = ~rst;
    {key_clear, key_start, key_right, key_left, key_dec, key_inc} = k;
    model_step(k, rst);
    exp_q.push_back(model_out());
  endtask

  task automatic press(input int idx);
    cyc(6'(1 << idx), 1'b0);
    cyc(6'd0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(6'd0, 1'b0);
  endtask

  task automatic do_reset();
    cyc(6'd0, 1'b1);
    cyc(6'd0, 1'b0);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d at t=%0t", nm, act, want, $time);
    end
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("value", 32'(value), x.value);
        chk("blink_mask", 32'(blink_mask), x.blink);
        chk("point_mask", 32'(point_mask), POINT_MASK);
        chk("state", 32'(state), x.st);
        chk("warn", 32'(warn), x.warn);
        chk("done_pulse", 32'(done_pulse), x.done_p);
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int guard;
    m_prev = '0;
    model_step(6'd0, 1'b1);
    // Start held through reset release must not register as a press.
    cyc(6'd0, 1'b1);
    cyc(6'b010000, 1'b1);
    cyc(6'b010000, 1'b0);
    cyc(6'b010000, 1'b0);
    idle(2);

    // Preset edit: 1300 with digit select moves.
    for (int i = 0; i < 3; i++) press(K_INC);
    press(K_LEFT);
    press(K_INC);

    // Upper bound 999999, then inc ignored.
    do_reset();
    press(K_RIGHT); press(K_RIGHT);
    for (int d = 0; d < DIGITS; d++) begin
      for (int i = 0; i < 9; i++) press(K_INC);
      press(K_LEFT);
    end
    press(K_INC);

    // Dec underflow guard and select wrap.
    do_reset();
    press(K_RIGHT);
    for (int i = 0; i < 5; i++) press(K_INC);
    press(K_LEFT);
    press(K_DEC);
    for (int i = 0; i < 4; i++) press(K_LEFT);
    cyc(6'b001100, 1'b0);
    cyc(6'b000011, 1'b0);
    idle(1);

    // 302 countdown crossing into WARN.
    do_reset();
    for (int i = 0; i < 3; i++) press(K_INC);
    press(K_RIGHT); press(K_RIGHT);
    press(K_INC); press(K_INC);
    press(K_START);
    idle(10);
    press(K_CLEAR);
    press(K_START);
    press(K_CLEAR);

    // Preset 3 runs to DONE.
    do_reset();
    press(K_RIGHT); press(K_RIGHT);
    for (int i = 0; i < 3; i++) press(K_INC);
    press(K_START);
    idle(10);
    press(K_START);

    // Pause at 500, hold, then start+clear together.
    do_reset();
    for (int i = 0; i < 5; i++) press(K_INC);
    press(K_RIGHT); press(K_RIGHT);
    press(K_INC); press(K_INC);
    press(K_START);
    guard = 0;
    while (!(m_cnt == 500 && m_st == M_RUN) && guard < 50) begin
      cyc(6'd0, 1'b0);
      guard++;
    end
    press(K_START);
    idle(20);
    cyc(6'b110000, 1'b0);
    idle(2);

    // Held start gives one press; reset mid-run loses preset.
    do_reset();
    press(K_RIGHT);
    press(K_INC);
    for (int i = 0; i < 100; i++) cyc(6'b010000, 1'b0);
    idle(1);
    press(K_START);
    press(K_START);
    idle(3);
    cyc(6'd0, 1'b1);
    idle(2);

    // Random key traffic.
    for (int n = 0; n < 600; n++) begin
      int r, hold;
      bit [5:0] k;
      r = $urandom_range(0, 99);
      hold = $urandom_range(1, 3);
      if (r < 1) k = 6'd0;
      else if (r < 5) k = 6'b110000;
      else if (r < 15) k = 6'd1 << K_START;
      else k = 6'(1 << $urandom_range(0, 5));
      if (r < 1) cyc(6'd0, 1'b1);
      else for (int h = 0; h < hold; h++) cyc(k, 1'b0);
      idle($urandom_range(0, 6));
    end

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #3;
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
